sample_strip_iter: RTL and testbench

//  Raster-stage iterator and transmitter feeding the jitter-hash stage's R14 input bus.

---
 rtl/sample_strip_iter.sv | 133 +++++++++++++
 tb/tb_sample_strip_iter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/sample_strip_iter.sv
// Raster-order box iterator: walks a snapped bounding box and emits one horizontal
// strip of SAMPS subsample centres per cycle, with the triangle and colour alongside.
module sample_strip_iter #(
   parameter int SIGFIG = 24,
   parameter int RADIX  = 10,
   parameter int VERTS  = 3,
   parameter int AXIS   = 3,
   parameter int COLORS = 3,
   parameter int SAMPS  = 4
) (
   input  logic                                     clk,
   input  logic                                     rst,
   input  logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R13S,
   input  logic [COLORS-1:0][SIGFIG-1:0]            color_R13U,
   input  logic [1:0][1:0][SIGFIG-1:0]              box_R13S,
   input  logic                                     validTri_R13H,
   input  logic [3:0]                               subSample_RnnnnU,
   output logic                                     halt_RnnnnL,
   output logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0]   tri_R14S,
   output logic [COLORS-1:0][SIGFIG-1:0]            color_R14U,
   output logic [1:0][SAMPS-1:0][SIGFIG-1:0]        sample_R14S,
   output logic [SAMPS-1:0]                         validSamp_R14H
);

   // One guard bit so lane and cursor arithmetic never wraps at the positive edge.
   localparam int W = SIGFIG + 1;

   typedef enum logic {WAIT, TEST} state_t;

   state_t state, state_nxt;

   logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_q;
   logic [COLORS-1:0][SIGFIG-1:0]          color_q;
   logic signed [W-1:0] step_q, ur_x_q, ur_y_q, ll_x_q, cx_q, cy_q;

   logic signed [W-1:0] box_ll_x, box_ll_y, box_ur_x, box_ur_y;
   logic signed [W-1:0] step_in;
   logic signed [W-1:0] lane_x [SAMPS];
   logic signed [W-1:0] next_x, next_y;
   logic [SAMPS-1:0]    lane_valid;
   logic                box_empty;
   logic                adv_x, adv_y;

   assign box_ll_x  = {box_R13S[0][0][SIGFIG-1], box_R13S[0][0]};
   assign box_ll_y  = {box_R13S[0][1][SIGFIG-1], box_R13S[0][1]};
   assign box_ur_x  = {box_R13S[1][0][SIGFIG-1], box_R13S[1][0]};
   assign box_ur_y  = {box_R13S[1][1][SIGFIG-1], box_R13S[1][1]};
   assign box_empty = (box_ur_x < box_ll_x) || (box_ur_y < box_ll_y);

   assign halt_RnnnnL = (state == WAIT);

   // NOTE: every always_comb output gets a default first so no path can infer a latch.
   always_comb begin
      step_in = W'(1) << RADIX;
      if      (subSample_RnnnnU[3]) step_in = W'(1) << RADIX;
      else if (subSample_RnnnnU[2]) step_in = W'(1) << (RADIX - 1);
      else if (subSample_RnnnnU[1]) step_in = W'(1) << (RADIX - 2);
      else if (subSample_RnnnnU[0]) step_in = W'(1) << (RADIX - 3);
   end

   always_comb begin
      lane_x[0]     = cx_q;
      lane_valid[0] = (cx_q <= ur_x_q);
      for (int k = 1; k < SAMPS; k++) begin
         lane_x[k]     = lane_x[k-1] + step_q;
         lane_valid[k] = (lane_x[k] <= ur_x_q);
      end
      next_x = lane_x[SAMPS-1] + step_q;
      next_y = cy_q + step_q;
      adv_x  = (next_x <= ur_x_q);
      adv_y  = (next_y <= ur_y_q);
   end

   always_comb begin
      state_nxt = state;
      case (state)
         WAIT: if (validTri_R13H && !box_empty) state_nxt = TEST;
         TEST: if (!adv_x && !adv_y)            state_nxt = WAIT;
         default:                               state_nxt = WAIT;
      endcase
   end

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk) begin
      if (rst) state <= WAIT;
      else     state <= state_nxt;
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         tri_q          <= '0;
         color_q        <= '0;
         step_q         <= '0;
         ll_x_q         <= '0;
         ur_x_q         <= '0;
         ur_y_q         <= '0;
         cx_q           <= '0;
         cy_q           <= '0;
         tri_R14S       <= '0;
         color_R14U     <= '0;
         sample_R14S    <= '0;
         validSamp_R14H <= '0;
      end else if (state == WAIT) begin
         validSamp_R14H <= '0;
         // Empty boxes are latched too; they are simply never iterated.
         if (validTri_R13H) begin
            tri_q   <= tri_R13S;
            color_q <= color_R13U;
            step_q  <= step_in;
            ll_x_q  <= box_ll_x;
            ur_x_q  <= box_ur_x;
            ur_y_q  <= box_ur_y;
            cx_q    <= box_ll_x;
            cy_q    <= box_ll_y;
         end
      end else begin
         tri_R14S       <= tri_q;
         color_R14U     <= color_q;
         validSamp_R14H <= lane_valid;
         for (int k = 0; k < SAMPS; k++) begin
            sample_R14S[0][k] <= lane_x[k][SIGFIG-1:0];
            sample_R14S[1][k] <= cy_q[SIGFIG-1:0];
         end
         if (adv_x) begin
            cx_q <= next_x;
         end else if (adv_y) begin
            cx_q <= ll_x_q;
            cy_q <= next_y;
         end
      end
   end

endmodule

// File: tb/tb_sample_strip_iter.sv
// Directed bench for sample_strip_iter: inputs change and outputs are checked on the
// falling edge, so every observation sits half a cycle away from the active edge.
module tb_sample_strip_iter;

   localparam int SIGFIG = 24;
   localparam int RADIX  = 10;
   localparam int VERTS  = 3;
   localparam int AXIS   = 3;
   localparam int COLORS = 3;
   localparam int SAMPS  = 4;

   typedef logic [VERTS-1:0][AXIS-1:0][SIGFIG-1:0] tri_t;
   typedef logic [COLORS-1:0][SIGFIG-1:0]          color_t;
   typedef logic [SAMPS-1:0][SIGFIG-1:0]           lanes_t;

   logic                             clk = 1'b0;
   logic                             rst;
   tri_t                             tri_R13S;
   color_t                           color_R13U;
   logic [1:0][1:0][SIGFIG-1:0]      box_R13S;
   logic                             validTri_R13H;
   logic [3:0]                       subSample_RnnnnU;
   logic                             halt_RnnnnL;
   tri_t                             tri_R14S;
   color_t                           color_R14U;
   logic [1:0][SAMPS-1:0][SIGFIG-1:0] sample_R14S;
   logic [SAMPS-1:0]                 validSamp_R14H;

   int n_checks = 0;
   int n_errors = 0;

   sample_strip_iter #(
      .SIGFIG(SIGFIG), .RADIX(RADIX), .VERTS(VERTS),
      .AXIS(AXIS), .COLORS(COLORS), .SAMPS(SAMPS)
   ) dut (
      .clk             (clk),
      .rst             (rst),
      .tri_R13S        (tri_R13S),
      .color_R13U      (color_R13U),
      .box_R13S        (box_R13S),
      .validTri_R13H   (validTri_R13H),
      .subSample_RnnnnU(subSample_RnnnnU),
      .halt_RnnnnL     (halt_RnnnnL),
      .tri_R14S        (tri_R14S),
      .color_R14U      (color_R14U),
      .sample_R14S     (sample_R14S),
      .validSamp_R14H  (validSamp_R14H)
   );

   always #5 clk = ~clk;

   function automatic tri_t make_tri(int seed);
      tri_t t;
      for (int v = 0; v < VERTS; v++)
         for (int a = 0; a < AXIS; a++)
            t[v][a] = SIGFIG'(seed * 100 + v * 10 + a + 1);
      return t;
   endfunction

   function automatic color_t make_color(int seed);
      color_t c;
      for (int i = 0; i < COLORS; i++) c[i] = SIGFIG'(seed * 7 + i + 1);
      return c;
   endfunction

   function automatic lanes_t lanes(int x0, int x1, int x2, int x3);
      lanes_t l;
      l[0] = SIGFIG'(x0);
      l[1] = SIGFIG'(x1);
      l[2] = SIGFIG'(x2);
      l[3] = SIGFIG'(x3);
      return l;
   endfunction

   task automatic check(string tag, logic [255:0] observed, logic [255:0] expected);
      n_checks++;
      assert (observed === expected) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, observed, expected);
      end
   endtask

   task automatic check_strip(string tag, logic [3:0] v, int x0, int x1, int x2, int x3, int y);
      check({tag, ".valid"}, 256'(validSamp_R14H), 256'(v));
      check({tag, ".x"}, 256'(sample_R14S[0]), 256'(lanes(x0, x1, x2, x3)));
      check({tag, ".y"}, 256'(sample_R14S[1]), 256'(lanes(y, y, y, y)));
   endtask

   task automatic present(int llx, int lly, int urx, int ury, logic [3:0] ss, int seed);
      box_R13S[0][0]   = SIGFIG'(llx);
      box_R13S[0][1]   = SIGFIG'(lly);
      box_R13S[1][0]   = SIGFIG'(urx);
      box_R13S[1][1]   = SIGFIG'(ury);
      tri_R13S         = make_tri(seed);
      color_R13U       = make_color(seed);
      subSample_RnnnnU = ss;
      validTri_R13H    = 1'b1;
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation did not finish in time");
      $fatal(1, "watchdog expired");
   end

   initial begin
      rst              = 1'b1;
      tri_R13S         = '0;
      color_R13U       = '0;
      box_R13S         = '0;
      validTri_R13H    = 1'b0;
      subSample_RnnnnU = 4'b1000;

      // Reset held for two rising edges.
      repeat (2) @(posedge clk);
      @(negedge clk);
      rst = 1'b0;
      check("rst.halt",  256'(halt_RnnnnL), 256'(1'b1));
      check("rst.valid", 256'(validSamp_R14H), 256'(4'b0000));
      check("rst.tri",   256'(tri_R14S), 256'(0));
      check("rst.color", 256'(color_R14U), 256'(0));
      check("rst.samp",  256'(sample_R14S), 256'(0));

      // MSAA1 two-row box: two full strips, then a bubble.
      present(0, 0, 3072, 1024, 4'b1000, 1);
      @(negedge clk);
      validTri_R13H = 1'b0;
      check("m1.c1.halt",  256'(halt_RnnnnL), 256'(1'b0));
      check("m1.c1.valid", 256'(validSamp_R14H), 256'(4'b0000));
      @(negedge clk);
      check("m1.c2.halt", 256'(halt_RnnnnL), 256'(1'b0));
      check_strip("m1.s0", 4'b1111, 0, 1024, 2048, 3072, 0);
      check("m1.tri",   256'(tri_R14S), 256'(make_tri(1)));
      check("m1.color", 256'(color_R14U), 256'(make_color(1)));
      @(negedge clk);
      check("m1.c3.halt", 256'(halt_RnnnnL), 256'(1'b1));
      check_strip("m1.s1", 4'b1111, 0, 1024, 2048, 3072, 1024);
      @(negedge clk);
      check("m1.bub.halt",  256'(halt_RnnnnL), 256'(1'b1));
      check("m1.bub.valid", 256'(validSamp_R14H), 256'(4'b0000));
      check("m1.bub.tri",   256'(tri_R14S), 256'(make_tri(1)));

      // MSAA4 single strip with the last lane past UR.x.
      present(1024, 0, 2048, 0, 4'b0100, 2);
      @(negedge clk);
      validTri_R13H = 1'b0;
      check("m4.c1.halt", 256'(halt_RnnnnL), 256'(1'b0));
      @(negedge clk);
      check("m4.c2.halt", 256'(halt_RnnnnL), 256'(1'b1));
      check_strip("m4.s0", 4'b0111, 1024, 1536, 2048, 2560, 0);
      @(negedge clk);
      check("m4.bub.valid", 256'(validSamp_R14H), 256'(4'b0000));

      // Single-pixel box at negative coordinates.
      present(-1024, -1024, -1024, -1024, 4'b1000, 3);
      @(negedge clk);
      validTri_R13H = 1'b0;
      @(negedge clk);
      check_strip("neg.s0", 4'b0001, -1024, 0, 1024, 2048, -1024);
      check("neg.tri", 256'(tri_R14S), 256'(make_tri(3)));
      @(negedge clk);
      check("neg.bub.valid", 256'(validSamp_R14H), 256'(4'b0000));

      // Inverted box is consumed without output; the next triangle goes in right after.
      present(2048, 0, 1024, 0, 4'b1000, 4);
      @(negedge clk);
      check("emp.halt",  256'(halt_RnnnnL), 256'(1'b1));
      check("emp.valid", 256'(validSamp_R14H), 256'(4'b0000));
      check("emp.tri",   256'(tri_R14S), 256'(make_tri(3)));
      present(0, 0, 0, 0, 4'b1000, 5);
      @(negedge clk);
      validTri_R13H = 1'b0;
      check("emp.next.halt", 256'(halt_RnnnnL), 256'(1'b0));
      @(negedge clk);
      check_strip("emp.next.s0", 4'b0001, 0, 1024, 2048, 3072, 0);
      check("emp.next.tri", 256'(tri_R14S), 256'(make_tri(5)));
      @(negedge clk);

      // Step latched at accept; subSample change mid-triangle ignored; reset mid-TEST.
      present(0, 0, 2048, 2048, 4'b1000, 6);
      @(negedge clk);
      validTri_R13H    = 1'b0;
      subSample_RnnnnU = 4'b0001;
      check("ss.c1.halt", 256'(halt_RnnnnL), 256'(1'b0));
      @(negedge clk);
      check_strip("ss.s0", 4'b0111, 0, 1024, 2048, 3072, 0);
      @(negedge clk);
      check_strip("ss.s1", 4'b0111, 0, 1024, 2048, 3072, 1024);
      check("ss.s1.halt", 256'(halt_RnnnnL), 256'(1'b0));
      rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      check("mrst.halt",  256'(halt_RnnnnL), 256'(1'b1));
      check("mrst.valid", 256'(validSamp_R14H), 256'(4'b0000));
      check("mrst.tri",   256'(tri_R14S), 256'(0));
      check("mrst.samp",  256'(sample_R14S), 256'(0));
      @(negedge clk);
      check("mrst.c2.halt",  256'(halt_RnnnnL), 256'(1'b1));
      check("mrst.c2.valid", 256'(validSamp_R14H), 256'(4'b0000));

      // MSAA64 (STEP=128) now that the triangle has gone back to WAIT.
      present(0, 0, 256, 0, 4'b0001, 7);
      @(negedge clk);
      validTri_R13H = 1'b0;
      @(negedge clk);
      check_strip("m64.s0", 4'b0111, 0, 128, 256, 384, 0);
      @(negedge clk);

      // Back-to-back: second triangle held valid while the first iterates.
      present(0, 0, 1024, 0, 4'b1000, 8);
      @(negedge clk);
      present(0, 0, 0, 1024, 4'b1000, 9);
      check("b2b.c1.halt", 256'(halt_RnnnnL), 256'(1'b0));
      @(negedge clk);
      check_strip("b2b.t8.s0", 4'b0011, 0, 1024, 2048, 3072, 0);
      check("b2b.t8.tri",  256'(tri_R14S), 256'(make_tri(8)));
      check("b2b.t8.halt", 256'(halt_RnnnnL), 256'(1'b1));
      @(negedge clk);
      validTri_R13H = 1'b0;
      check("b2b.bub.valid", 256'(validSamp_R14H), 256'(4'b0000));
      check("b2b.bub.halt",  256'(halt_RnnnnL), 256'(1'b0));
      check("b2b.bub.tri",   256'(tri_R14S), 256'(make_tri(8)));
      @(negedge clk);
      check_strip("b2b.t9.s0", 4'b0001, 0, 1024, 2048, 3072, 0);
      check("b2b.t9.tri",   256'(tri_R14S), 256'(make_tri(9)));
      check("b2b.t9.color", 256'(color_R14U), 256'(make_color(9)));
      @(negedge clk);
      check_strip("b2b.t9.s1", 4'b0001, 0, 1024, 2048, 3072, 1024);
      check("b2b.t9.halt", 256'(halt_RnnnnL), 256'(1'b1));
      @(negedge clk);
      check("b2b.end.valid", 256'(validSamp_R14H), 256'(4'b0000));

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
